switch_arbiter: RTL

SWITCH_ARBITER -- requirements
Module: switch_arbiter

---
 rtl/switch_arbiter_if.sv | 52 +++++
 rtl/switch_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/switch_arbiter_if.sv
// ---------------------------------------------------------------------------
// switch_arbiter_if
// Purpose : bundles the two requester ports, the arbitration enable and the
//           registered beat toward the switch datapath into one interface.
// Signals : enable                                  arbitration allowed
//           req0_valid/ready/addr/data              requester port 0
//           req1_valid/ready/addr/data              requester port 1
//           out_valid/out_addr/out_data/out_src     granted beat
//           fifo0_level/fifo1_level                 per-port FIFO occupancy
// Modports: master = requester/datapath side, slave = the arbiter itself.
// ---------------------------------------------------------------------------
interface switch_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                  enable;
   logic                  req0_valid;
   logic                  req0_ready;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  out_valid;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_src;
   logic [LW-1:0]         fifo0_level;
   logic [LW-1:0]         fifo1_level;

   modport master (
      output enable,
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  out_valid, out_addr, out_data, out_src,
      input  fifo0_level, fifo1_level
   );

   modport slave (
      input  enable,
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output out_valid, out_addr, out_data, out_src,
      output fifo0_level, fifo1_level
   );
endinterface

// File: rtl/switch_arbiter.sv
// ---------------------------------------------------------------------------
// switch_arbiter
// Purpose : two requester FIFOs feeding a single registered output beat,
//           arbitrated round-robin when both FIFOs hold data.
// Ports   : clk    sole clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    switch_arbiter_if.slave (requester ports, enable,
//                  output beat, FIFO levels)
// ---------------------------------------------------------------------------
module switch_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   switch_arbiter_if.slave       bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   typedef logic [EW-1:0] entry_t;

   entry_t                mem [2][FIFO_DEPTH];
   logic [PW-1:0]         wrPtr_q [2];
   logic [PW-1:0]         wrPtr_d [2];
   logic [PW-1:0]         rdPtr_q [2];
   logic [PW-1:0]         rdPtr_d [2];
   logic [LW-1:0]         level_q [2];
   logic [LW-1:0]         level_d [2];
   logic                  readyEn_q;
   logic                  lastGrant_q;
   logic                  lastGrant_d;
   logic                  outValid_q;
   logic                  outValid_d;
   logic [ADDR_WIDTH-1:0] outAddr_q;
   logic [ADDR_WIDTH-1:0] outAddr_d;
   logic [DATA_WIDTH-1:0] outData_q;
   logic [DATA_WIDTH-1:0] outData_d;
   logic                  outSrc_q;
   logic                  outSrc_d;

   logic [1:0]            reqValid;
   entry_t                reqEntry [2];
   logic [1:0]            ready;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0]            nonEmpty;
   logic                  grant;
   logic                  grantPort;
   entry_t                popEntry;

   // Ready is held low until the first edge after reset release (readyEn_q).
   // A full FIFO refuses a push even when it is being popped the same cycle.
   // With both FIFOs occupied the port that did not win last time is granted;
   // last grant resets to 1 so the first tie goes to port 0.
   always_comb begin
      reqValid    = {bus.req1_valid, bus.req0_valid};
      reqEntry[0] = {bus.req0_addr, bus.req0_data};
      reqEntry[1] = {bus.req1_addr, bus.req1_data};
      for (int i = 0; i < 2; i++) begin
         ready[i]    = readyEn_q && (level_q[i] != LW'(FIFO_DEPTH));
         push[i]     = reqValid[i] && ready[i];
         nonEmpty[i] = (level_q[i] != '0);
      end
      grant = bus.enable && (nonEmpty != 2'b00);
      if (nonEmpty == 2'b11) begin
         grantPort = ~lastGrant_q;
      end else begin
         grantPort = nonEmpty[1];
      end
      pop = 2'b00;
      if (grant) begin
         pop[grantPort] = 1'b1;
      end
      popEntry = mem[grantPort][rdPtr_q[grantPort]];
   end

   // Pointer and level bookkeeping; pointers wrap naturally because the depth
   // is a power of two. A simultaneous push and pop leaves the level as is.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         wrPtr_d[i] = push[i] ? wrPtr_q[i] + PW'(1) : wrPtr_q[i];
         rdPtr_d[i] = pop[i]  ? rdPtr_q[i] + PW'(1) : rdPtr_q[i];
         level_d[i] = level_q[i];
         if (push[i] && !pop[i]) begin
            level_d[i] = level_q[i] + LW'(1);
         end else if (pop[i] && !push[i]) begin
            level_d[i] = level_q[i] - LW'(1);
         end
      end
      lastGrant_d = grant ? grantPort : lastGrant_q;
      outValid_d  = grant;
      outAddr_d   = grant ? popEntry[EW-1:DATA_WIDTH] : '0;
      outData_d   = grant ? popEntry[DATA_WIDTH-1:0] : '0;
      outSrc_d    = grant ? grantPort : 1'b0;
   end

   // Control state: cleared asynchronously, so queued words are discarded
   // the moment reset asserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wrPtr_q[i] <= '0;
            rdPtr_q[i] <= '0;
            level_q[i] <= '0;
         end
         readyEn_q   <= 1'b0;
         lastGrant_q <= 1'b1;
         outValid_q  <= 1'b0;
         outAddr_q   <= '0;
         outData_q   <= '0;
         outSrc_q    <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            wrPtr_q[i] <= wrPtr_d[i];
            rdPtr_q[i] <= rdPtr_d[i];
            level_q[i] <= level_d[i];
         end
         readyEn_q   <= 1'b1;
         lastGrant_q <= lastGrant_d;
         outValid_q  <= outValid_d;
         outAddr_q   <= outAddr_d;
         outData_q   <= outData_d;
         outSrc_q    <= outSrc_d;
      end
   end

   // FIFO storage needs no reset; stale contents are unreachable once the
   // pointers and levels are cleared.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem[i][wrPtr_q[i]] <= reqEntry[i];
         end
      end
   end

   assign bus.req0_ready  = ready[0];
   assign bus.req1_ready  = ready[1];
   assign bus.fifo0_level = level_q[0];
   assign bus.fifo1_level = level_q[1];
   assign bus.out_valid   = outValid_q;
   assign bus.out_addr    = outAddr_q;
   assign bus.out_data    = outData_q;
   assign bus.out_src     = outSrc_q;
endmodule
